// File: rtl/rat_cp_if.sv
// rtl/rat_cp_if.sv - rename group, checkpoint control and status bundle for rat_cp.
interface rat_cp_if #(
    parameter int WIDTH = 4,
    parameter int PW    = 6,
    parameter int CW    = 3
);
    logic [WIDTH-1:0]    i_in_valid;
    logic [WIDTH*5-1:0]  i_rs1;
    logic [WIDTH*5-1:0]  i_rs2;
    logic [WIDTH*5-1:0]  i_rd;
    logic [WIDTH-1:0]    i_rd_valid;
    logic [WIDTH*PW-1:0] i_prd_new;
    logic [WIDTH-1:0]    i_is_br;
    logic [WIDTH*PW-1:0] o_prs1;
    logic [WIDTH*PW-1:0] o_prs2;
    logic [WIDTH*PW-1:0] o_prev_prd;
    logic [WIDTH*CW-1:0] o_cp_tag;
    logic                o_ready;
    logic                i_recover;
    logic [CW-1:0]       i_recover_tag;
    logic                i_release;
    logic [CW:0]         o_cp_count;

    modport master (
        output i_in_valid, i_rs1, i_rs2, i_rd, i_rd_valid, i_prd_new, i_is_br,
        output i_recover, i_recover_tag, i_release,
        input  o_prs1, o_prs2, o_prev_prd, o_cp_tag, o_ready, o_cp_count
    );

    modport slave (
        input  i_in_valid, i_rs1, i_rs2, i_rd, i_rd_valid, i_prd_new, i_is_br,
        input  i_recover, i_recover_tag, i_release,
        output o_prs1, o_prs2, o_prev_prd, o_cp_tag, o_ready, o_cp_count
    );
endinterface

// File: rtl/rat_cp.sv
// rtl/rat_cp.sv - register alias table with circular checkpoint buffer; RAT_RECOVER_FWD_EN
// lets a recover cycle also rename the incoming group against the restored snapshot.
module rat_cp #(
    parameter int WIDTH   = 4,
    parameter int ARF_NUM = 32,
    parameter int PRF_NUM = 64,
    parameter int CP_NUM  = 8,
    localparam int PW     = $clog2(PRF_NUM),
    localparam int CW     = $clog2(CP_NUM)
) (
    input  logic     i_clock,
    input  logic     i_reset,
    rat_cp_if.slave  bus
);
    typedef logic [ARF_NUM-1:0][PW-1:0] map_t;

    map_t          r_map;
    map_t          r_ckpt [CP_NUM];
    logic [CW:0]   r_head;
    logic [CW:0]   r_tail;

    map_t          w_base;
    map_t          w_stage [WIDTH+1];
    logic [WIDTH-1:0] w_wr;
    logic [WIDTH-1:0] w_brl;
    logic [CW-1:0] w_slot [WIDTH];
    logic [CW:0]   w_count;
    logic [CW:0]   w_free;
    logic [CW:0]   w_nbr;
    logic [CW:0]   w_rec_ptr;
    logic [CW:0]   w_tail_base;
    logic [CW:0]   w_tail_next;
    logic          w_recover_block;
    logic          w_ready;
    logic          w_accept;

`ifdef RAT_RECOVER_FWD_EN
    assign w_recover_block = 1'b0;
`else
    assign w_recover_block = bus.i_recover;
`endif

    always_comb begin
        logic [4:0] v_rs1;
        logic [4:0] v_rs2;
        logic [4:0] v_rd;
        v_rs1 = '0;
        v_rs2 = '0;
        v_rd  = '0;
        bus.o_prs1     = '0;
        bus.o_prs2     = '0;
        bus.o_prev_prd = '0;
        bus.o_cp_tag   = '0;
        w_wr  = '0;
        w_brl = '0;
        w_nbr = '0;
        w_count = r_tail - r_head;
        w_free  = (CW+1)'(CP_NUM) - w_count;
        // Recover tag is a slot index; rebuild its wrap bit relative to head.
        w_rec_ptr = {r_head[CW] ^ (bus.i_recover_tag < r_head[CW-1:0]), bus.i_recover_tag};
        w_base      = bus.i_recover ? r_ckpt[bus.i_recover_tag] : r_map;
        w_tail_base = bus.i_recover ? w_rec_ptr + (CW+1)'(1) : r_tail;
        w_stage[0]  = w_base;
        for (int i = 0; i < WIDTH; i++) begin
            v_rs1 = bus.i_rs1[i*5 +: 5];
            v_rs2 = bus.i_rs2[i*5 +: 5];
            v_rd  = bus.i_rd[i*5 +: 5];
            w_wr[i]  = bus.i_in_valid[i] & bus.i_rd_valid[i] & (v_rd != 5'd0);
            w_brl[i] = bus.i_in_valid[i] & bus.i_is_br[i];
            w_slot[i] = w_tail_base[CW-1:0] + w_nbr[CW-1:0];
            bus.o_cp_tag[i*CW +: CW]   = w_slot[i];
            bus.o_prs1[i*PW +: PW]     = (v_rs1 == 5'd0) ? '0 : w_stage[i][v_rs1];
            bus.o_prs2[i*PW +: PW]     = (v_rs2 == 5'd0) ? '0 : w_stage[i][v_rs2];
            bus.o_prev_prd[i*PW +: PW] = w_wr[i] ? w_stage[i][v_rd] : '0;
            // Each stage is the map after this lane, so later lanes see the youngest writer.
            w_stage[i+1] = w_stage[i];
            if (w_wr[i]) begin
                w_stage[i+1][v_rd] = bus.i_prd_new[i*PW +: PW];
            end
            w_nbr = w_nbr + (CW+1)'(w_brl[i]);
        end
        w_ready     = (w_free >= w_nbr) && !w_recover_block;
        w_accept    = w_ready;
        w_tail_next = w_tail_base + (w_accept ? w_nbr : '0);
        bus.o_ready    = w_ready;
        bus.o_cp_count = w_count;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int a = 0; a < ARF_NUM; a++) begin
                r_map[a] <= PW'(a);
            end
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_map  <= w_accept ? w_stage[WIDTH] : w_base;
            r_tail <= w_tail_next;
            if (bus.i_release && (w_count != '0)) begin
                r_head <= r_head + (CW+1)'(1);
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (w_accept && w_brl[i]) begin
                    r_ckpt[w_slot[i]] <= w_stage[i+1];
                end
            end
        end
    end

    a_recover_tag_live: assert property (@(posedge i_clock) disable iff (i_reset)
        bus.i_recover |-> ((w_rec_ptr - r_head) < w_count));
endmodule

// File: tb/tb_rat_cp.sv
// tb/tb_rat_cp.sv - scoreboard bench for rat_cp; expectations come from a reference rename model.
module tb_rat_cp;
    localparam int W  = 4;
    localparam int PW = 6;
    localparam int CW = 3;
`ifdef RAT_RECOVER_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst;

    rat_cp_if #(.WIDTH(W), .PW(PW), .CW(CW)) bus ();

    rat_cp #(.WIDTH(W), .ARF_NUM(32), .PRF_NUM(64), .CP_NUM(8)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    kind;
        int    lane;
        int    exp;
        string tag;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;
    bit  g_rst = 1'b0;

    int l_v[W], l_rs1[W], l_rs2[W], l_rd[W], l_rdv[W], l_prd[W], l_br[W];
    int m_map[32];
    int m_cur[32];
    int m_ckpt[8][32];
    int m_head, m_tail;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int observe(input int kind, input int lane);
        case (kind)
            0: return int'(bus.o_prs1[lane*PW +: PW]);
            1: return int'(bus.o_prs2[lane*PW +: PW]);
            2: return int'(bus.o_prev_prd[lane*PW +: PW]);
            3: return int'(bus.o_cp_tag[lane*CW +: CW]);
            4: return int'(bus.o_ready);
            default: return int'(bus.o_cp_count);
        endcase
    endfunction

    task automatic expect_c(input int kind, input int lane, input int val, input string tag);
        sb_t e;
        e.kind = kind;
        e.lane = lane;
        e.exp  = val;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < W; i++) begin
            l_v[i] = 0; l_rs1[i] = 0; l_rs2[i] = 0; l_rd[i] = 0;
            l_rdv[i] = 0; l_prd[i] = 0; l_br[i] = 0;
        end
    endtask

    function automatic bit lane_writes(input int j);
        return (l_v[j] != 0) && (l_rdv[j] != 0) && (l_rd[j] != 0);
    endfunction

    // Search older lanes newest-first, then fall back to the base map.
    function automatic int lookup(input int r, input int lane);
        if (r == 0) return 0;
        for (int j = lane - 1; j >= 0; j--) begin
            if (lane_writes(j) && l_rd[j] == r) return l_prd[j];
        end
        return m_cur[r];
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 32; a++) m_map[a] = a;
        m_head = 0;
        m_tail = 0;
    endtask

    task automatic step(input bit rec, input int rtag, input bit rel);
        int cnt, nbr, tbase, recabs, nth;
        bit rdy, acc;
        sb_t e;
        @(negedge clk);
        rst = g_rst;
        for (int i = 0; i < W; i++) begin
            bus.i_in_valid[i]        = (l_v[i] != 0);
            bus.i_rd_valid[i]        = (l_rdv[i] != 0);
            bus.i_is_br[i]           = (l_br[i] != 0);
            bus.i_rs1[i*5 +: 5]      = 5'(l_rs1[i]);
            bus.i_rs2[i*5 +: 5]      = 5'(l_rs2[i]);
            bus.i_rd[i*5 +: 5]       = 5'(l_rd[i]);
            bus.i_prd_new[i*PW +: PW] = PW'(l_prd[i]);
        end
        bus.i_recover     = rec;
        bus.i_recover_tag = CW'(rtag);
        bus.i_release     = rel;

        cnt = m_tail - m_head;
        nbr = 0;
        for (int i = 0; i < W; i++) if (l_v[i] != 0 && l_br[i] != 0) nbr++;
        rdy = (8 - cnt >= nbr) && !(rec && !FWD);
        acc = rdy;
        recabs = m_tail;
        if (rec) begin
            for (int k = m_head; k < m_tail; k++) if (k % 8 == rtag) recabs = k;
        end
        for (int a = 0; a < 32; a++) m_cur[a] = rec ? m_ckpt[rtag][a] : m_map[a];
        tbase = rec ? recabs + 1 : m_tail;

        if (!g_rst) begin
            nth = 0;
            for (int i = 0; i < W; i++) begin
                if (l_v[i] != 0 && (!rec || FWD)) begin
                    expect_c(0, i, lookup(l_rs1[i], i), $sformatf("prs1[%0d]", i));
                    expect_c(1, i, lookup(l_rs2[i], i), $sformatf("prs2[%0d]", i));
                    expect_c(2, i, lane_writes(i) ? lookup(l_rd[i], i) : 0,
                             $sformatf("prev_prd[%0d]", i));
                end
                if (acc && l_v[i] != 0 && l_br[i] != 0) begin
                    expect_c(3, i, (tbase + nth) % 8, $sformatf("cp_tag[%0d]", i));
                    nth++;
                end
            end
            expect_c(4, 0, int'(rdy), "ready");
            expect_c(5, 0, cnt, "cp_count");
        end
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.kind, e.lane), e.exp);
        end

        @(posedge clk);
        if (g_rst) begin
            model_reset();
        end else begin
            nth = 0;
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    if (lane_writes(i)) m_cur[l_rd[i]] = l_prd[i];
                    if (l_v[i] != 0 && l_br[i] != 0) begin
                        for (int a = 0; a < 32; a++) m_ckpt[(tbase + nth) % 8][a] = m_cur[a];
                        nth++;
                    end
                end
            end
            for (int a = 0; a < 32; a++) m_map[a] = m_cur[a];
            m_tail = tbase + (acc ? nbr : 0);
            if (rel && cnt > 0) m_head++;
        end
    endtask

    task automatic do_reset();
        clear_lanes();
        g_rst = 1'b1;
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        g_rst = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        bus.i_in_valid = '0; bus.i_rd_valid = '0; bus.i_is_br = '0;
        bus.i_rs1 = '0; bus.i_rs2 = '0; bus.i_rd = '0; bus.i_prd_new = '0;
        bus.i_recover = 1'b0; bus.i_recover_tag = '0; bus.i_release = 1'b0;
        model_reset();
        do_reset();

        // Reset map lookups and idle status.
        for (int i = 0; i < W; i++) begin
            l_v[i] = 1; l_rs1[i] = i + 1;
            expect_c(0, i, i + 1, "rst_prs1");
            expect_c(2, i, 0, "rst_prev");
        end
        expect_c(4, 0, 1, "rst_ready");
        expect_c(5, 0, 0, "rst_count");
        step(1'b0, 0, 1'b0);
        clear_lanes();
        step(1'b0, 0, 1'b1);

        // Intra-group bypass; lane0 must not see later writers.
        clear_lanes();
        l_v[0] = 1; l_rs1[0] = 5; l_rd[0] = 5; l_rdv[0] = 1; l_prd[0] = 40;
        l_v[1] = 1; l_rs2[1] = 5; l_rd[1] = 5; l_rdv[1] = 1; l_prd[1] = 41;
        l_v[2] = 1; l_rs1[2] = 5;
        expect_c(0, 0, 5, "byp_lane0");
        expect_c(1, 1, 40, "byp_prs2");
        expect_c(2, 1, 40, "byp_prev");
        expect_c(0, 2, 41, "byp_prs1");
        expect_c(5, 0, 0, "rel_empty_ignored");
        step(1'b0, 0, 1'b0);
        clear_lanes();
        l_v[0] = 1; l_rs1[0] = 5;
        expect_c(0, 0, 41, "map5_after");
        step(1'b0, 0, 1'b0);

        // Snapshot slot 2 holds 7->50; recover restores it.
        do_reset();
        clear_lanes(); l_v[0] = 1; l_br[0] = 1;
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        clear_lanes();
        l_v[0] = 1; l_rd[0] = 7; l_rdv[0] = 1; l_prd[0] = 50;
        l_v[1] = 1; l_br[1] = 1;
        expect_c(3, 1, 2, "cp_slot2");
        step(1'b0, 0, 1'b0);
        clear_lanes(); l_v[0] = 1; l_rd[0] = 7; l_rdv[0] = 1; l_prd[0] = 51;
        step(1'b0, 0, 1'b0);
        clear_lanes();
        step(1'b1, 2, 1'b0);
        l_v[0] = 1; l_rs1[0] = 7;
        expect_c(0, 0, 50, "rec_map7");
        expect_c(5, 0, 3, "rec_count");
        step(1'b0, 0, 1'b0);

        // Fill all eight slots, then stall a ninth branch.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            clear_lanes();
            l_v[0] = 1; l_br[0] = 1; l_rd[0] = k + 1; l_rdv[0] = 1; l_prd[0] = 32 + k;
            step(1'b0, 0, 1'b0);
        end
        clear_lanes();
        l_v[0] = 1; l_br[0] = 1; l_rd[0] = 3; l_rdv[0] = 1; l_prd[0] = 60;
        expect_c(5, 0, 8, "full_count");
        expect_c(4, 0, 0, "full_ready");
        step(1'b0, 0, 1'b0);
        clear_lanes(); l_v[0] = 1; l_rs1[0] = 3;
        expect_c(0, 0, 34, "full_nowrite");
        step(1'b0, 0, 1'b1);
        clear_lanes(); l_v[0] = 1; l_br[0] = 1;
        expect_c(4, 0, 1, "rel_ready");
        expect_c(3, 0, 0, "wrap_slot");
        step(1'b0, 0, 1'b0);

        // Recover and release the same single slot empties the buffer at 1.
        do_reset();
        clear_lanes(); l_v[0] = 1; l_br[0] = 1;
        step(1'b0, 0, 1'b0);
        clear_lanes();
        expect_c(5, 0, 1, "one_count");
        step(1'b1, 0, 1'b1);
        for (int i = 0; i < W; i++) begin l_v[i] = 1; l_br[i] = 1; end
        expect_c(5, 0, 0, "recrel_empty");
        expect_c(3, 0, 1, "recrel_tail1");
        step(1'b0, 0, 1'b0);
        expect_c(3, 3, 0, "tail_wrap");
        step(1'b0, 0, 1'b0);

        // Recover with a concurrent valid group.
        do_reset();
        clear_lanes(); l_v[0] = 1; l_br[0] = 1; l_rd[0] = 9; l_rdv[0] = 1; l_prd[0] = 45;
        step(1'b0, 0, 1'b0);
        clear_lanes(); l_v[0] = 1; l_rd[0] = 9; l_rdv[0] = 1; l_prd[0] = 46;
        step(1'b0, 0, 1'b0);
        clear_lanes(); l_v[0] = 1; l_rs1[0] = 9; l_rd[0] = 10; l_rdv[0] = 1; l_prd[0] = 47;
        expect_c(4, 0, FWD ? 1 : 0, "recfwd_ready");
        if (FWD) expect_c(0, 0, 45, "recfwd_prs1");
        step(1'b1, 0, 1'b0);
        clear_lanes(); l_v[0] = 1; l_rs1[0] = 10; l_rs2[0] = 9;
        expect_c(0, 0, FWD ? 47 : 10, "recfwd_map10");
        expect_c(1, 0, 45, "recfwd_map9");
        step(1'b0, 0, 1'b0);

        // Random traffic with legal recover tags only.
        for (int n = 0; n < 300; n++) begin
            bit rec;
            int rtag;
            clear_lanes();
            for (int i = 0; i < W; i++) begin
                l_v[i]   = ($urandom_range(0, 3) != 0) ? 1 : 0;
                l_rs1[i] = $urandom_range(0, 31);
                l_rs2[i] = $urandom_range(0, 31);
                l_rd[i]  = $urandom_range(0, 31);
                l_rdv[i] = $urandom_range(0, 1);
                l_prd[i] = $urandom_range(32, 63);
                l_br[i]  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            end
            cnt  = m_tail - m_head;
            rec  = (cnt > 0) && ($urandom_range(0, 7) == 0);
            rtag = rec ? (m_head + $urandom_range(0, cnt - 1)) % 8 : 0;
            step(rec, rtag, ($urandom_range(0, 3) == 0));
        end

        // Reset asserted with a group and a recover in flight.
        cnt = m_tail - m_head;
        for (int i = 0; i < W; i++) begin
            l_v[i] = 1; l_br[i] = 1; l_rd[i] = i + 1; l_rdv[i] = 1; l_prd[i] = 50 + i;
        end
        g_rst = 1'b1;
        step(cnt > 0, m_head % 8, 1'b1);
        g_rst = 1'b0;
        clear_lanes();
        for (int i = 0; i < W; i++) begin
            l_v[i] = 1; l_rs1[i] = i + 1;
            expect_c(0, i, i + 1, "midrst_prs1");
        end
        expect_c(5, 0, 0, "midrst_count");
        expect_c(4, 0, 1, "midrst_ready");
        step(1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
